alu_seq_control: RTL and testbench

ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

---
 rtl/alu_ctrl_pkg.sv | 27 ++
 rtl/alu_ctrl_decode.sv | 49 ++++
 rtl/alu_seq_control.sv | 131 +++++++++++++
 tb/tb_alu_seq_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALU op selects, funct codes,
// ALUOp classes from main control and the sequencer state type.
package alu_ctrl_pkg;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;
  localparam int unsigned ALU_SLT = 4;

  localparam int unsigned FN_MUL = 5;
  localparam int unsigned FN_DIV = 6;
  localparam int unsigned FN_JR  = 8;

  localparam int unsigned ALUOP_RTYPE = 0;
  localparam int unsigned ALUOP_SUB   = 1;
  localparam int unsigned ALUOP_SLT   = 2;
  localparam int unsigned ALUOP_ADD   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder: ALU select, jump-register, multiply/divide
// classification and unsupported-encoding flag.
import alu_ctrl_pkg::*;

module alu_ctrl_decode #(
  parameter int ALUOP_W = 2,
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 3
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               jr,
  output logic               is_mul,
  output logic               is_div,
  output logic               illegal
);

  always_comb begin
    ctrl    = CTRL_W'(ALU_ADD);
    jr      = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    illegal = 1'b0;
    if (alu_op == ALUOP_W'(ALUOP_ADD)) begin
      ctrl = CTRL_W'(ALU_ADD);
    end else if (alu_op == ALUOP_W'(ALUOP_SLT)) begin
      ctrl = CTRL_W'(ALU_SLT);
    end else if (alu_op == ALUOP_W'(ALUOP_SUB)) begin
      ctrl = CTRL_W'(ALU_SUB);
    end else if (alu_op == ALUOP_W'(ALUOP_RTYPE)) begin
      // funct 0..4 is already the ALU select encoding
      if (funct <= FUNCT_W'(ALU_SLT)) begin
        ctrl = CTRL_W'(funct[2:0]);
      end else if (funct == FUNCT_W'(FN_JR)) begin
        jr = 1'b1;
      end else if (funct == FUNCT_W'(FN_MUL)) begin
        is_mul = 1'b1;
      end else if (funct == FUNCT_W'(FN_DIV)) begin
        is_div = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_control.sv
// ALU control sequencer: single-cycle decode results with latency 1, and
// multi-cycle multiply/divide occupancy tracked by a down-counter FSM.
import alu_ctrl_pkg::*;

module alu_seq_control #(
  parameter int ALUOP_W    = 2,
  parameter int FUNCT_W    = 4,
  parameter int CTRL_W     = 3,
  parameter int MUL_CYCLES = 8,
  parameter int DIV_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               jr_ctrl,
  output logic               illegal,
  output logic               mdu_start,
  output logic               mdu_sel,
  output logic               busy,
  output logic               out_valid
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_jr;
  logic              dec_mul;
  logic              dec_div;
  logic              dec_ill;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              jr_p1;
  logic              ill_p1;
  logic              start_p1;
  logic              sel_p1;
  logic              vld_p1;

  alu_ctrl_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .jr      (dec_jr),
    .is_mul  (dec_mul),
    .is_div  (dec_div),
    .illegal (dec_ill)
  );

  // stage p0 -> p1: accept, sequence and register results
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ctrl_p1  <= '0;
      jr_p1    <= 1'b0;
      ill_p1   <= 1'b0;
      start_p1 <= 1'b0;
      sel_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      start_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      if (flush) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        sel_p1 <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid) begin
              ctrl_p1 <= dec_ctrl;
              jr_p1   <= dec_jr;
              ill_p1  <= dec_ill;
              if (dec_mul) begin
                state    <= ST_MUL;
                cnt      <= CNT_W'(MUL_CYCLES - 1);
                start_p1 <= 1'b1;
                sel_p1   <= 1'b0;
              end else if (dec_div) begin
                state    <= ST_DIV;
                cnt      <= CNT_W'(DIV_CYCLES - 1);
                start_p1 <= 1'b1;
                sel_p1   <= 1'b1;
              end else begin
                vld_p1 <= 1'b1;
              end
            end
          end
          ST_MUL, ST_DIV: begin
            if (cnt == '0) begin
              state   <= ST_DONE;
              vld_p1  <= 1'b1;
              ctrl_p1 <= CTRL_W'(ALU_ADD);
              jr_p1   <= 1'b0;
              ill_p1  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            sel_p1 <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign alu_ctrl  = ctrl_p1;
  assign jr_ctrl   = jr_p1;
  assign illegal   = ill_p1;
  assign mdu_start = start_p1;
  assign mdu_sel   = sel_p1;
  // A redirect arriving during DONE cancels the completion it would report
  assign out_valid = vld_p1 & ~(flush & (state == ST_DONE));

endmodule

// File: tb/tb_alu_seq_control.sv
// Randomized and directed bench for alu_seq_control against an occupancy-count
// reference model, plus literal expectations for the key scenarios.
module tb_alu_seq_control;

  localparam int ALUOP_W = 3;
  localparam int FUNCT_W = 4;
  localparam int CTRL_W  = 3;
  localparam int MUL_C   = 8;
  localparam int DIV_C   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ALUOP_W-1:0] alu_op = '0;
  logic [FUNCT_W-1:0] funct = '0;
  logic               flush = 1'b0;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               jr_ctrl;
  logic               illegal;
  logic               mdu_start;
  logic               mdu_sel;
  logic               busy;
  logic               out_valid;

  int n_chk = 0;
  int n_fail = 0;
  int ov_cnt = 0;

  alu_seq_control #(
    .ALUOP_W    (ALUOP_W),
    .FUNCT_W    (FUNCT_W),
    .CTRL_W     (CTRL_W),
    .MUL_CYCLES (MUL_C),
    .DIV_CYCLES (DIV_C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .flush     (flush),
    .alu_ctrl  (alu_ctrl),
    .jr_ctrl   (jr_ctrl),
    .illegal   (illegal),
    .mdu_start (mdu_start),
    .mdu_sel   (mdu_sel),
    .busy      (busy),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the encoding table.
  // kind: 0 single-cycle, 1 multiply, 2 divide
  function automatic void ref_dec(input int op, input int f, output int kind,
                                  output int c, output bit j, output bit il);
    kind = 0; c = 0; j = 0; il = 0;
    if (op == 3) c = 0;
    else if (op == 2) c = 4;
    else if (op == 1) c = 1;
    else if (op == 0) begin
      if (f <= 4) c = f;
      else if (f == 8) j = 1;
      else if (f == 5) kind = 1;
      else if (f == 6) kind = 2;
      else il = 1;
    end else il = 1;
  endfunction

  // Model: occ = number of remaining occupied cycles (0 means idle)
  int occ = 0;
  bit e_vld = 0, e_start = 0, e_sel = 0, e_jr = 0, e_ill = 0, m_ok = 0;
  int e_ctrl = 0;

  always @(posedge clk) begin : model
    int kind, c;
    bit j, il;
    if (reset) begin
      occ = 0; e_vld = 0; e_start = 0; e_sel = 0;
      e_ctrl = 0; e_jr = 0; e_ill = 0; m_ok = 1;
    end else if (flush) begin
      occ = 0; e_vld = 0; e_start = 0; e_sel = 0;
    end else if (occ > 0) begin
      occ--;
      e_start = 0;
      e_vld = (occ == 1);
      if (occ == 1) begin e_ctrl = 0; e_jr = 0; e_ill = 0; end
      if (occ == 0) e_sel = 0;
    end else begin
      e_start = 0;
      e_vld = 0;
      if (in_valid) begin
        ref_dec(int'(alu_op), int'(funct), kind, c, j, il);
        e_ctrl = c; e_jr = j; e_ill = il;
        if (kind == 0) e_vld = 1;
        else begin
          occ = ((kind == 1) ? MUL_C : DIV_C) + 1;
          e_start = 1;
          e_sel = (kind == 2);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit exp_ov;
    if (out_valid === 1'b1) ov_cnt++;
    if (m_ok) begin
      exp_ov = e_vld && !(flush && occ == 1);
      chk("m_in_ready", int'(in_ready), int'(occ == 0));
      chk("m_busy", int'(busy), int'(occ > 0));
      chk("m_mdu_start", int'(mdu_start), int'(e_start));
      chk("m_mdu_sel", int'(mdu_sel), int'(e_sel));
      chk("m_out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov) begin
        chk("m_alu_ctrl", int'(alu_ctrl), e_ctrl);
        chk("m_jr_ctrl", int'(jr_ctrl), int'(e_jr));
        chk("m_illegal", int'(illegal), int'(e_ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int op, input int f, input bit fl);
    in_valid = v;
    alu_op = ALUOP_W'(op);
    funct = FUNCT_W'(f);
    flush = fl;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_alu_ctrl"}, int'(alu_ctrl), 0);
    chk({tag, "_jr_ctrl"}, int'(jr_ctrl), 0);
    chk({tag, "_illegal"}, int'(illegal), 0);
    chk({tag, "_mdu_start"}, int'(mdu_start), 0);
    chk({tag, "_mdu_sel"}, int'(mdu_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, reqs, first_acc;
    bit acc;
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    check_reset_vals("rst");

    // ALU op funct 3
    set_in(1, 0, 3, 0); step(); set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("or_out_valid", int'(out_valid), 1);
    chk("or_alu_ctrl", int'(alu_ctrl), 3);
    chk("or_busy", int'(busy), 0);
    chk("or_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // jr then ALUOp 2
    set_in(1, 0, 8, 0); step();
    set_in(1, 2, 0, 0);
    @(negedge clk);
    chk("jr_jr_ctrl", int'(jr_ctrl), 1);
    chk("jr_alu_ctrl", int'(alu_ctrl), 0);
    @(posedge clk); #1; set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("op2_alu_ctrl", int'(alu_ctrl), 4);
    chk("op2_jr_ctrl", int'(jr_ctrl), 0);
    @(posedge clk); #1;

    // multiply latency profile
    set_in(1, 0, 5, 0); step(); set_in(0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("mul_start_c%0d", k), int'(mdu_start), int'(k == 1));
      chk($sformatf("mul_busy_c%0d", k), int'(busy), int'(k <= 9));
      chk($sformatf("mul_ov_c%0d", k), int'(out_valid), int'(k == 9));
      chk($sformatf("mul_ready_c%0d", k), int'(in_ready), int'(k == 10));
      if (k == 9) chk("mul_done_ctrl", int'(alu_ctrl), 0);
      @(posedge clk); #1;
    end

    // divide followed by held back-to-back ALU ops
    set_in(1, 0, 6, 0); step();
    base = ov_cnt; reqs = 0; first_acc = -1;
    set_in(1, 0, 1, 0);
    @(negedge clk);
    chk("div_mdu_sel", int'(mdu_sel), 1);
    chk("div_mdu_start", int'(mdu_start), 1);
    @(posedge clk); #1;
    for (int k = 2; k <= 60 && reqs < 3; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready && !flush;
      if (acc) begin
        if (first_acc < 0) first_acc = k;
        reqs++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (reqs == 3) in_valid = 1'b0;
        else funct = FUNCT_W'(reqs + 1);
      end
    end
    set_in(0, 0, 0, 0);
    step(); step();
    chk("b2b_requests", reqs, 3);
    chk("b2b_first_accept_cycle", first_acc, DIV_C + 2);
    chk("b2b_out_valid_count", ov_cnt - base, 4);

    // divide flushed at cycle 5, then an illegal funct
    set_in(1, 0, 6, 0); step(); set_in(0, 0, 0, 0);
    base = ov_cnt;
    for (int k = 1; k < 5; k++) step();
    flush = 1'b1; step(); flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 1);
    chk("flush_busy", int'(busy), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) step();
    chk("flush_no_out_valid", ov_cnt - base, 0);
    set_in(1, 0, 15, 0); step(); set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("ill_illegal", int'(illegal), 1);
    chk("ill_alu_ctrl", int'(alu_ctrl), 0);
    chk("ill_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;

    // reset mid-multiply, overriding flush and in_valid
    set_in(1, 0, 5, 0); step(); set_in(0, 0, 0, 0);
    step(); step(); step();
    reset = 1'b1; set_in(1, 0, 5, 1); step();
    reset = 1'b0; set_in(0, 0, 0, 0);
    check_reset_vals("midrst");

    // flush coinciding with a request
    set_in(1, 0, 5, 1); step(); set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("flushreq_busy", int'(busy), 0);
    chk("flushreq_mdu_start", int'(mdu_start), 0);
    chk("flushreq_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 24) == 0);
      in_valid = $urandom_range(0, 1);
      alu_op = ($urandom_range(0, 1) == 1) ? '0 : ALUOP_W'($urandom_range(0, 7));
      funct = ($urandom_range(0, 2) == 0) ? FUNCT_W'($urandom_range(5, 6))
                                          : FUNCT_W'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
